// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock.
// bcd_out/overflow are registered and only update on the edge that raises done.
//
// state | meaning
// IDLE  | waiting for start; captures bin_in when start is high
// SHIFT | one add-3/shift iteration per clock, BIN_W iterations
// DONE  | one-cycle result pulse; start here begins the next conversion
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [BIN_W-1:0]     bin_sr;
    logic [4*DIGITS-1:0]  bcd_wr;
    logic [4*DIGITS-1:0]  bcd_adj;
    logic [4*DIGITS-1:0]  bcd_next;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_acc;
    logic                 shift_out;
    logic                 last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign bcd_adj[4*g +: 4] = (bcd_wr[4*g +: 4] >= 4'd5) ? bcd_wr[4*g +: 4] + 4'd3
                                                               : bcd_wr[4*g +: 4];
    end

    // The bit leaving the top digit carries weight 10^DIGITS, so dropping it
    // leaves the low DIGITS decimal digits intact.
    assign shift_out = bcd_adj[4*DIGITS-1];
    assign bcd_next  = {bcd_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_wr   <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        bcd_wr  <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    bcd_wr  <= bcd_next;
                    bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                    ovf_acc <= ovf_acc | shift_out;
                    if (last_iter) begin
                        bcd_out  <= bcd_next;
                        overflow <= ovf_acc | shift_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
